// File: rtl/sdc_regs_pkg.sv
// rtl/sdc_regs_pkg.sv - SD controller register map, widths and event bit indices
// Shared by the Wishbone register slave and the bus master that programs it.
package sdc_regs_pkg;

    localparam logic [7:0] SDC_ADDR_ARGUMENT      = 8'h00;
    localparam logic [7:0] SDC_ADDR_COMMAND       = 8'h04;
    localparam logic [7:0] SDC_ADDR_RESP0         = 8'h08;
    localparam logic [7:0] SDC_ADDR_RESP1         = 8'h0C;
    localparam logic [7:0] SDC_ADDR_RESP2         = 8'h10;
    localparam logic [7:0] SDC_ADDR_RESP3         = 8'h14;
    localparam logic [7:0] SDC_ADDR_DATA_TIMEOUT  = 8'h18;
    localparam logic [7:0] SDC_ADDR_CONTROL       = 8'h1C;
    localparam logic [7:0] SDC_ADDR_CMD_TIMEOUT   = 8'h20;
    localparam logic [7:0] SDC_ADDR_CLK_DIV       = 8'h24;
    localparam logic [7:0] SDC_ADDR_RESET         = 8'h28;
    localparam logic [7:0] SDC_ADDR_VOLTAGE       = 8'h2C;
    localparam logic [7:0] SDC_ADDR_CAPABILITIES  = 8'h30;
    localparam logic [7:0] SDC_ADDR_CMD_EVT_STAT  = 8'h34;
    localparam logic [7:0] SDC_ADDR_CMD_EVT_EN    = 8'h38;
    localparam logic [7:0] SDC_ADDR_DATA_EVT_STAT = 8'h3C;
    localparam logic [7:0] SDC_ADDR_DATA_EVT_EN   = 8'h40;
    localparam logic [7:0] SDC_ADDR_BLK_SIZE      = 8'h44;
    localparam logic [7:0] SDC_ADDR_BLK_COUNT     = 8'h48;
    localparam logic [7:0] SDC_ADDR_XFER_ADDR     = 8'h60;

    localparam int SDC_CMD_W     = 14;
    localparam int SDC_TIMEOUT_W = 24;
    localparam int SDC_CLKDIV_W  = 8;
    localparam int SDC_EVT_W     = 5;
    localparam int SDC_BLKSIZE_W = 12;
    localparam int SDC_BLKCNT_W  = 16;

    localparam int SDC_EVT_CMD_DONE  = 0;
    localparam int SDC_EVT_CMD_ERR   = 1;
    localparam int SDC_EVT_CRC_ERR   = 2;
    localparam int SDC_EVT_INDEX_ERR = 3;
    localparam int SDC_EVT_TIMEOUT   = 4;

    // Byte-lane merge of a bus write into the current register contents.
    function automatic logic [31:0] sdc_merge(input logic [31:0] old,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = sel[i] ? wdat[8*i +: 8] : old[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/sdc_evt_reg.sv
// rtl/sdc_evt_reg.sv - W1C event status, enable register and interrupt OR
// A set pulse beats a simultaneous write-1-to-clear on the same bit.
module sdc_evt_reg
    import sdc_regs_pkg::*;
(
    input  logic                 wb_clk,
    input  logic                 reset,
    input  logic [SDC_EVT_W-1:0] evt_set,
    input  logic                 status_we,
    input  logic [SDC_EVT_W-1:0] clr,
    input  logic                 enable_we,
    input  logic [SDC_EVT_W-1:0] enable_d,
    output logic [SDC_EVT_W-1:0] status,
    output logic [SDC_EVT_W-1:0] enable,
    output logic                 irq
);

    always_ff @(posedge wb_clk or posedge reset) begin
        if (reset) begin
            status <= '0;
            enable <= '0;
        end else begin
            status <= (status & ~(status_we ? clr : '0)) | evt_set;
            if (enable_we)
                enable <= enable_d;
        end
    end

    assign irq = |(status & enable);

endmodule

// File: rtl/sdc_wb_slave_regs.sv
// rtl/sdc_wb_slave_regs.sv - Wishbone classic register slave for the SD controller
// Writes commit and read data is captured on the edge that raises wb_ack_o.
module sdc_wb_slave_regs
    import sdc_regs_pkg::*;
#(
    parameter logic [31:0] CAPABILITIES  = 32'h0000_0000,
    parameter logic [31:0] VOLTAGE       = 32'h0000_0CE4,
    parameter logic [11:0] BLKSIZE_RESET = 12'd511
) (
    input  logic                     wb_clk,
    input  logic                     reset,
    input  logic [7:0]               wb_adr_i,
    input  logic [31:0]              wb_dat_i,
    output logic [31:0]              wb_dat_o,
    input  logic [3:0]               wb_sel_i,
    input  logic                     wb_we_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    output logic                     wb_ack_o,
    output logic [31:0]              argument_o,
    output logic [SDC_CMD_W-1:0]     command_o,
    input  logic [127:0]             resp_i,
    output logic [SDC_TIMEOUT_W-1:0] data_timeout_o,
    output logic                     bus_width_o,
    output logic [SDC_TIMEOUT_W-1:0] cmd_timeout_o,
    output logic [SDC_CLKDIV_W-1:0]  clk_div_o,
    output logic                     soft_rst_o,
    input  logic [SDC_EVT_W-1:0]     cmd_evt_set_i,
    input  logic [SDC_EVT_W-1:0]     data_evt_set_i,
    output logic                     int_cmd_o,
    output logic                     int_data_o,
    output logic [SDC_BLKSIZE_W-1:0] blk_size_o,
    output logic [SDC_BLKCNT_W-1:0]  blk_count_o,
    output logic [31:0]              xfer_addr_o,
    output logic                     cmd_start_o
);

    logic [7:0]           adr;
    logic                 ack_q;
    logic                 ack_next;
    logic                 commit;
    logic                 arg_wr_q;
    logic [31:0]          rd_mux;
    logic [SDC_EVT_W-1:0] cmd_status, cmd_enable, data_status, data_enable;
    logic [SDC_EVT_W-1:0] w1c_bits;
    logic                 unused_adr;

    assign adr        = {wb_adr_i[7:2], 2'b00};
    assign unused_adr = ^wb_adr_i[1:0];

    // Gating with cyc&stb lets ack vanish at once if the master abandons the cycle.
    assign wb_ack_o = ack_q & wb_cyc_i & wb_stb_i;
    assign ack_next = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign commit   = ack_next & wb_we_i;
    assign w1c_bits = wb_dat_i[SDC_EVT_W-1:0] & {SDC_EVT_W{wb_sel_i[0]}};

    always_comb begin
        rd_mux = '0;
        case (adr)
            SDC_ADDR_ARGUMENT:      rd_mux = argument_o;
            SDC_ADDR_COMMAND:       rd_mux = 32'(command_o);
            SDC_ADDR_RESP0:         rd_mux = resp_i[31:0];
            SDC_ADDR_RESP1:         rd_mux = resp_i[63:32];
            SDC_ADDR_RESP2:         rd_mux = resp_i[95:64];
            SDC_ADDR_RESP3:         rd_mux = resp_i[127:96];
            SDC_ADDR_DATA_TIMEOUT:  rd_mux = 32'(data_timeout_o);
            SDC_ADDR_CONTROL:       rd_mux = 32'(bus_width_o);
            SDC_ADDR_CMD_TIMEOUT:   rd_mux = 32'(cmd_timeout_o);
            SDC_ADDR_CLK_DIV:       rd_mux = 32'(clk_div_o);
            SDC_ADDR_RESET:         rd_mux = 32'(soft_rst_o);
            SDC_ADDR_VOLTAGE:       rd_mux = VOLTAGE;
            SDC_ADDR_CAPABILITIES:  rd_mux = CAPABILITIES;
            SDC_ADDR_CMD_EVT_STAT:  rd_mux = 32'(cmd_status);
            SDC_ADDR_CMD_EVT_EN:    rd_mux = 32'(cmd_enable);
            SDC_ADDR_DATA_EVT_STAT: rd_mux = 32'(data_status);
            SDC_ADDR_DATA_EVT_EN:   rd_mux = 32'(data_enable);
            SDC_ADDR_BLK_SIZE:      rd_mux = 32'(blk_size_o);
            SDC_ADDR_BLK_COUNT:     rd_mux = 32'(blk_count_o);
            SDC_ADDR_XFER_ADDR:     rd_mux = xfer_addr_o;
            default:                rd_mux = '0;
        endcase
    end

    always_ff @(posedge wb_clk or posedge reset) begin
        if (reset) begin
            ack_q          <= 1'b0;
            wb_dat_o       <= '0;
            arg_wr_q       <= 1'b0;
            cmd_start_o    <= 1'b0;
            argument_o     <= '0;
            command_o      <= '0;
            data_timeout_o <= '0;
            bus_width_o    <= 1'b0;
            cmd_timeout_o  <= '0;
            clk_div_o      <= '0;
            soft_rst_o     <= 1'b0;
            blk_size_o     <= BLKSIZE_RESET;
            blk_count_o    <= '0;
            xfer_addr_o    <= '0;
        end else begin
            ack_q <= ack_next;
            if (ack_next)
                wb_dat_o <= rd_mux;
            // Start strobe lands one cycle behind the argument write's ack.
            arg_wr_q    <= commit && (adr == SDC_ADDR_ARGUMENT);
            cmd_start_o <= arg_wr_q;
            if (commit) begin
                case (adr)
                    SDC_ADDR_ARGUMENT:
                        argument_o <= sdc_merge(argument_o, wb_dat_i, wb_sel_i);
                    SDC_ADDR_COMMAND:
                        command_o <= SDC_CMD_W'(sdc_merge(32'(command_o), wb_dat_i, wb_sel_i));
                    SDC_ADDR_DATA_TIMEOUT:
                        data_timeout_o <= SDC_TIMEOUT_W'(sdc_merge(32'(data_timeout_o), wb_dat_i, wb_sel_i));
                    SDC_ADDR_CONTROL:
                        bus_width_o <= wb_sel_i[0] ? wb_dat_i[0] : bus_width_o;
                    SDC_ADDR_CMD_TIMEOUT:
                        cmd_timeout_o <= SDC_TIMEOUT_W'(sdc_merge(32'(cmd_timeout_o), wb_dat_i, wb_sel_i));
                    SDC_ADDR_CLK_DIV:
                        clk_div_o <= wb_sel_i[0] ? wb_dat_i[7:0] : clk_div_o;
                    SDC_ADDR_RESET:
                        soft_rst_o <= wb_sel_i[0] ? wb_dat_i[0] : soft_rst_o;
                    SDC_ADDR_BLK_SIZE:
                        blk_size_o <= SDC_BLKSIZE_W'(sdc_merge(32'(blk_size_o), wb_dat_i, wb_sel_i));
                    SDC_ADDR_BLK_COUNT:
                        blk_count_o <= SDC_BLKCNT_W'(sdc_merge(32'(blk_count_o), wb_dat_i, wb_sel_i));
                    SDC_ADDR_XFER_ADDR:
                        xfer_addr_o <= sdc_merge(xfer_addr_o, wb_dat_i, wb_sel_i);
                    default: ;
                endcase
            end
        end
    end

    sdc_evt_reg u_cmd_evt (
        .wb_clk    (wb_clk),
        .reset     (reset),
        .evt_set   (cmd_evt_set_i),
        .status_we (commit && (adr == SDC_ADDR_CMD_EVT_STAT)),
        .clr       (w1c_bits),
        .enable_we (commit && (adr == SDC_ADDR_CMD_EVT_EN) && wb_sel_i[0]),
        .enable_d  (wb_dat_i[SDC_EVT_W-1:0]),
        .status    (cmd_status),
        .enable    (cmd_enable),
        .irq       (int_cmd_o)
    );

    sdc_evt_reg u_data_evt (
        .wb_clk    (wb_clk),
        .reset     (reset),
        .evt_set   (data_evt_set_i),
        .status_we (commit && (adr == SDC_ADDR_DATA_EVT_STAT)),
        .clr       (w1c_bits),
        .enable_we (commit && (adr == SDC_ADDR_DATA_EVT_EN) && wb_sel_i[0]),
        .enable_d  (wb_dat_i[SDC_EVT_W-1:0]),
        .status    (data_status),
        .enable    (data_enable),
        .irq       (int_data_o)
    );

endmodule
